// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer family.
// Holds the control state encoding and a constant clog2 helper used to size
// select, pointer and dwell-counter fields.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } mux_state_t;

    // Ceiling log2, never less than 1 so that derived vectors are always legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_n_1_comb.sv
// Pure combinational N:1 selector over a packed channel bus.
// Ports: din (N*W packed, channel k at din[k*W +: W]), sel (channel index), dout.
// An out-of-range sel yields zero; callers are expected to qualify it.
module mux_n_1_comb
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = clog2(N)
) (
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   dout
);

    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                dout = din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_n_1_seq.sv
// Registered N:1 mux with valid/ready output, direct-select and auto-scan modes.
// Ports: clk, rst_n (async, active-low), I (N*W channel data), S (direct select),
// mode (0 direct / 1 scan), en, out_ready -> Y, ch, out_valid, wrap, err.
// Latency 1 cycle; a stalled beat (out_valid & !out_ready) holds Y/ch/out_valid.
module mux_n_1_seq
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int DWELL = 1,
    localparam int SW   = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] I,
    input  logic [SW-1:0]  S,
    input  logic           mode,
    input  logic           en,
    input  logic           out_ready,
    output logic [W-1:0]   Y,
    output logic [SW-1:0]  ch,
    output logic           out_valid,
    output logic           wrap,
    output logic           err
);

    localparam int DCW = clog2(DWELL + 1);
    localparam logic [SW-1:0]  PTR_LAST   = SW'(N - 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

    mux_state_t     state, state_nxt;
    logic [SW-1:0]  ptr, ptr_nxt;
    logic [DCW-1:0] dwell_cnt, dwell_nxt;
    logic [W-1:0]   y_nxt;
    logic [SW-1:0]  ch_nxt;
    logic           valid_nxt, wrap_nxt, err_nxt;

    logic           slot_free;
    logic           s_in_range;
    logic [SW-1:0]  scan_idx;
    logic [DCW-1:0] scan_dwell;
    logic [W-1:0]   direct_dat, scan_dat;

    // Coming into SCAN from another state always starts at channel 0 with a
    // fresh dwell count, so the first capture uses zero rather than the stale ptr.
    assign scan_idx   = (state == SCAN) ? ptr : '0;
    assign scan_dwell = (state == SCAN) ? dwell_cnt : '0;
    assign slot_free  = !out_valid || out_ready;
    assign s_in_range = (int'(S) < N);

    mux_n_1_comb #(.N(N), .W(W), .SW(SW)) u_sel_direct (
        .din  (I),
        .sel  (S),
        .dout (direct_dat)
    );

    mux_n_1_comb #(.N(N), .W(W), .SW(SW)) u_sel_scan (
        .din  (I),
        .sel  (scan_idx),
        .dout (scan_dat)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dwell_nxt = dwell_cnt;
        y_nxt     = Y;
        ch_nxt    = ch;
        valid_nxt = out_valid;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (slot_free) begin
            if (!en) begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                ptr_nxt   = '0;
                dwell_nxt = '0;
            end else if (!mode) begin
                state_nxt = DIRECT;
                if (s_in_range) begin
                    y_nxt     = direct_dat;
                    ch_nxt    = S;
                    valid_nxt = 1'b1;
                end else begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                end
            end else begin
                state_nxt = SCAN;
                y_nxt     = scan_dat;
                ch_nxt    = scan_idx;
                valid_nxt = 1'b1;
                ptr_nxt   = scan_idx;
                if (scan_dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (scan_idx == PTR_LAST) begin
                        ptr_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ptr_nxt = scan_idx + 1'b1;
                    end
                end else begin
                    dwell_nxt = scan_dwell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            dwell_cnt <= '0;
            Y         <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            dwell_cnt <= dwell_nxt;
            Y         <= y_nxt;
            ch        <= ch_nxt;
            out_valid <= valid_nxt;
            wrap      <= wrap_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mux_n_1_seq.sv
// Directed self-checking bench for mux_n_1_seq.
// Main instance: N=4, W=8, DWELL=2. Second instance: N=5, W=8, DWELL=1 for out-of-range select.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mux_n_1_seq;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        en;
    logic        out_ready;

    logic [31:0] i4;
    logic [1:0]  s4;
    logic [7:0]  y4;
    logic [1:0]  ch4;
    logic        vld4, wrap4, err4;

    logic [39:0] i5;
    logic [2:0]  s5;
    logic [7:0]  y5;
    logic [2:0]  ch5;
    logic        vld5, wrap5, err5;

    int checks;
    int errors;

    mux_n_1_seq #(.N(4), .W(8), .DWELL(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (i4),
        .S         (s4),
        .mode      (mode),
        .en        (en),
        .out_ready (out_ready),
        .Y         (y4),
        .ch        (ch4),
        .out_valid (vld4),
        .wrap      (wrap4),
        .err       (err4)
    );

    mux_n_1_seq #(.N(5), .W(8), .DWELL(1)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (i5),
        .S         (s5),
        .mode      (mode),
        .en        (en),
        .out_ready (out_ready),
        .Y         (y5),
        .ch        (ch5),
        .out_valid (vld5),
        .wrap      (wrap5),
        .err       (err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 1'b0; en = 1'b0; out_ready = 1'b1;
        s4 = 2'd0; s5 = 3'd0;
        i4 = {8'h44, 8'h33, 8'h22, 8'h11};
        i5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        checks++;
        if ({y4, ch4, vld4, wrap4, err4} !== 13'd0) begin
            errors++;
            $display("FAIL reset_n4: got y=%h ch=%0d vld=%b wrap=%b err=%b, want all 0", y4, ch4, vld4, wrap4, err4);
        end
        checks++;
        if ({y5, ch5, vld5, wrap5, err5} !== 14'd0) begin
            errors++;
            $display("FAIL reset_n5: got y=%h ch=%0d vld=%b wrap=%b err=%b, want all 0", y5, ch5, vld5, wrap5, err5);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        mode = 1'b0; s4 = 2'd2; en = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (y4 !== 8'h33 || ch4 !== 2'd2 || vld4 !== 1'b1) begin
            errors++;
            $display("FAIL direct_s2: got y=%h ch=%0d vld=%b, want y=33 ch=2 vld=1", y4, ch4, vld4);
        end
    endtask

    task automatic test_backpressure();
        s4 = 2'd1;
        tick();
        checks++;
        if (y4 !== 8'h22 || ch4 !== 2'd1 || vld4 !== 1'b1) begin
            errors++;
            $display("FAIL bp_capture: got y=%h ch=%0d vld=%b, want y=22 ch=1 vld=1", y4, ch4, vld4);
        end
        out_ready = 1'b0;
        s4 = 2'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (y4 !== 8'h22 || ch4 !== 2'd1 || vld4 !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got y=%h ch=%0d vld=%b, want y=22 ch=1 vld=1", k, y4, ch4, vld4);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (y4 !== 8'h44 || ch4 !== 2'd3 || vld4 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got y=%h ch=%0d vld=%b, want y=44 ch=3 vld=1", y4, ch4, vld4);
        end
    endtask

    task automatic test_scan_wrap();
        logic [1:0] exp_ch [9];
        exp_ch = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        mode = 1'b1; out_ready = 1'b1; en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_y;
            logic       exp_wrap;
            exp_y    = 8'h11 * (8'(exp_ch[k]) + 8'd1);
            exp_wrap = (k == 7);
            tick();
            checks++;
            if (ch4 !== exp_ch[k] || y4 !== exp_y || vld4 !== 1'b1 || wrap4 !== exp_wrap) begin
                errors++;
                $display("FAIL scan_beat_%0d: got ch=%0d y=%h vld=%b wrap=%b, want ch=%0d y=%h vld=1 wrap=%b",
                         k, ch4, y4, vld4, wrap4, exp_ch[k], exp_y, exp_wrap);
            end
        end
    endtask

    task automatic test_disable_reenter();
        logic [1:0] exp_ch [4];
        exp_ch = '{2'd0, 2'd1, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (ch4 !== exp_ch[k] || vld4 !== 1'b1) begin
                errors++;
                $display("FAIL reenter_lead_%0d: got ch=%0d vld=%b, want ch=%0d vld=1", k, ch4, vld4, exp_ch[k]);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (vld4 !== 1'b0) begin
            errors++;
            $display("FAIL disable_gap: got vld=%b, want 0", vld4);
        end
        en = 1'b1;
        tick();
        checks++;
        if (ch4 !== 2'd0 || y4 !== 8'h11 || vld4 !== 1'b1) begin
            errors++;
            $display("FAIL reenter_first: got ch=%0d y=%h vld=%b, want ch=0 y=11 vld=1", ch4, y4, vld4);
        end
        tick();
        checks++;
        if (ch4 !== 2'd0 || vld4 !== 1'b1) begin
            errors++;
            $display("FAIL reenter_second: got ch=%0d vld=%b, want ch=0 vld=1", ch4, vld4);
        end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; en = 1'b1; out_ready = 1'b1;
        s5 = 3'd1;
        tick();
        checks++;
        if (y5 !== 8'h22 || ch5 !== 3'd1 || vld5 !== 1'b1 || err5 !== 1'b0) begin
            errors++;
            $display("FAIL oor_before: got y=%h ch=%0d vld=%b err=%b, want y=22 ch=1 vld=1 err=0", y5, ch5, vld5, err5);
        end
        s5 = 3'd6;
        tick();
        checks++;
        if (err5 !== 1'b1 || vld5 !== 1'b0 || y5 !== 8'h22 || ch5 !== 3'd1) begin
            errors++;
            $display("FAIL oor_err: got err=%b vld=%b y=%h ch=%0d, want err=1 vld=0 y=22 ch=1", err5, vld5, y5, ch5);
        end
        s5 = 3'd4;
        tick();
        checks++;
        if (err5 !== 1'b0 || vld5 !== 1'b1 || y5 !== 8'h55 || ch5 !== 3'd4) begin
            errors++;
            $display("FAIL oor_after: got err=%b vld=%b y=%h ch=%0d, want err=0 vld=1 y=55 ch=4", err5, vld5, y5, ch5);
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b0; en = 1'b1; out_ready = 1'b1; s4 = 2'd2;
        tick();
        out_ready = 1'b0;
        tick();
        checks++;
        if (vld4 !== 1'b1 || y4 !== 8'h33) begin
            errors++;
            $display("FAIL areset_pre: got vld=%b y=%h, want vld=1 y=33", vld4, y4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vld4 !== 1'b0 || y4 !== 8'h00 || ch4 !== 2'd0) begin
            errors++;
            $display("FAIL areset_immediate: got vld=%b y=%h ch=%0d, want vld=0 y=00 ch=0", vld4, y4, ch4);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_direct();
        test_backpressure();
        test_scan_wrap();
        test_disable_reenter();
        test_out_of_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_1_seq.md
# mux_n_1_seq

Registered, parametrised N:1 multiplexer with a valid/ready output stage and two select modes: direct (external select) and auto-scan (internal round-robin pointer with programmable dwell). It generalises the team's 4:1 behavioural mux to arbitrary channel count and data width. It sits between multi-channel sources and a single downstream consumer that can apply backpressure, such as a serialiser or monitor tap.

## Interface
- N, 4, number of input channels; N ≥ 2, need not be a power of two.
- W, 8, data width per channel.
- DWELL, 1, accepted beats per channel before the scan pointer advances; DWELL ≥ 1.
- SW, localparam, select width, clog2(N).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- I  input  N*W  packed channel data; channel k occupies I[k*W +: W].
- S  input  SW  channel select, used in direct mode only.
- mode  input  1  0 = direct, 1 = auto-scan.
- en  input  1  enable; 0 stops new captures.
- out_ready  input  1  downstream ready.
- Y  output  W  registered selected data.
- ch  output  SW  channel index of the beat currently on Y.
- out_valid  output  1  Y/ch hold a valid beat.
- wrap  output  1  one-cycle pulse, coincident with the beat that carries the scan pointer from N-1 to 0.
- err  output  1  one-cycle pulse when S ≥ N is sampled in direct mode.

## Operation
- States: IDLE, DIRECT, SCAN. Reset enters IDLE with Y=0, ch=0, out_valid=0, wrap=0, err=0, ptr=0, dwell count=0.
- Slot free: out_valid=0 or out_ready=1. Captures occur only on a free slot.
- IDLE: when en=1 on a free slot, move to DIRECT (mode=0) or SCAN (mode=1). The first capture happens in that same cycle.
- DIRECT: on a free slot with en=1, capture Y<=I[S], ch<=S, out_valid<=1.
  - If S ≥ N: no capture, err<=1, out_valid<=0, Y and ch hold.
- SCAN: on a free slot with en=1, capture Y<=I[ptr], ch<=ptr, out_valid<=1, and increment the dwell count.
  - When the dwell count reaches DWELL-1, the count clears and ptr advances. At N-1, ptr wraps to 0, and wrap=1 is asserted alongside that beat.
- Entering SCAN from any state resets ptr and the dwell count to 0.
- Mode change while the slot is stalled (out_valid=1, out_ready=0) takes effect only after the stall clears. Y, ch and out_valid stay stable throughout the stall.
- en=0 on a free slot: out_valid<=0, state goes to IDLE, and ptr is cleared. A stalled beat is never dropped by en=0.
- A beat transfers when out_valid=1 and out_ready=1.
- Asserting reset mid-operation clears everything immediately, with no handshake.

## Timing
- Latency: input to Y is 1 cycle; I and S are sampled on the capture edge.
- Throughput: 1 beat per cycle while out_ready=1.
- err and wrap are registered single-cycle pulses. They never stretch during a stall because they fire only on capture attempts.
- For non-power-of-two N, ptr never takes values ≥ N.

## Structure
- Shared package mux_pkg holds the state enum (IDLE/DIRECT/SCAN) and a clog2 constant function used for SW.
- The sub-module mux_n_1_comb is a pure combinational N:1 selector, parametrised on N and W. It is instantiated twice: once for the direct S path and once for the ptr path. Alternatively, one instance is fed a muxed index.
- The top level contains the state machine, ptr, the dwell counter and the output register.

## Test plan
- Reset and direct: N=4, W=8, I={8'h44,8'h33,8'h22,8'h11}, mode=0, S=2, en=1, out_ready=1. Required: Y=8'h33, ch=2, out_valid=1 one cycle after en. After reset, all outputs are 0.
- Backpressure: capture with S=1, then hold out_ready=0 for 3 cycles while S changes to 3. Required: Y=8'h22 and ch=1 stay stable. The cycle after out_ready=1, Y=8'h44.
- Scan wrap: mode=1, DWELL=2, out_ready=1. Required ch sequence is 0,0,1,1,2,2,3,3,0. wrap=1 only on the second ch=3 beat.
- Out-of-range select: N=5, S=6 in direct mode. Required: err=1 for exactly 1 cycle, out_valid=0, Y holds its previous value.
- Disable and re-enter: in scan at ch=2, drop en for 1 free cycle, then raise it again. Required: out_valid=0 for 1 cycle, then scan restarts at ch=0.
- Asynchronous reset mid-stall: pull rst_n low between clock edges while out_valid=1 and out_ready=0. Required: out_valid=0 and Y=0 immediately, with no clock edge needed.
